pwl_filter_cfg_sequencer: RTL and testbench

//  Clocked controller that owns the config/control pins of one pwl_filter_real_prime cell.

---
 rtl/pwl_filter_cfg_pkg.sv | 52 +++++
 rtl/pwl_filter_profile_tbl.sv | 60 ++++++
 rtl/pwl_filter_cfg_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pwl_filter_cfg_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_filter_cfg_pkg.sv
// Shared types, filter-type codes and profile validation for the pwl filter
// config sequencer and its profile table.
package pwl_filter_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RST    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5,
        ST_REJECT = 3'd6
    } state_t;

    localparam int FT_P1   = 0;
    localparam int FT_P2   = 1;
    localparam int FT_P2Z1 = 2;
    localparam int FT_P1Z1 = 3;

    typedef struct {
        real  wz1;
        real  wp1;
        real  wp2;
        int   ftype;
        logic cplx;
    } profile_t;

    localparam real  DEF_WZ1   = 1.0;
    localparam real  DEF_WP1   = 1.0;
    localparam real  DEF_WP2   = 2.0;
    localparam int   DEF_FTYPE = FT_P1;
    localparam logic DEF_CPLX  = 1'b0;

    // A complex pole pair needs a second-order type and a positive wp2;
    // real-pole types need every frequency they actually use to be positive.
    function automatic logic profile_valid(profile_t p);
        logic ok;
        ok = 1'b1;
        if (p.ftype < FT_P1 || p.ftype > FT_P1Z1) begin
            ok = 1'b0;
        end else if (p.cplx) begin
            if (p.ftype == FT_P1 || p.ftype == FT_P1Z1) ok = 1'b0;
            if (p.wp2 <= 0.0) ok = 1'b0;
        end else begin
            if (p.wp1 <= 0.0) ok = 1'b0;
            if ((p.ftype == FT_P2 || p.ftype == FT_P2Z1) && p.wp2 <= 0.0) ok = 1'b0;
            if ((p.ftype == FT_P2Z1 || p.ftype == FT_P1Z1) && p.wz1 <= 0.0) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pwl_filter_profile_tbl.sv
// Register table of filter coefficient profiles: synchronous write, asynchronous
// read, every entry returns to the default profile on reset.
module pwl_filter_profile_tbl
    import pwl_filter_cfg_pkg::*;
#(
    parameter int NUM_PROF = 4,
    localparam int PW = $clog2(NUM_PROF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_idx,
    input  real           wr_wz1,
    input  real           wr_wp1,
    input  real           wr_wp2,
    input  int            wr_ftype,
    input  logic          wr_cplx,
    input  logic [PW-1:0] rd_idx,
    output real           rd_wz1,
    output real           rd_wp1,
    output real           rd_wp2,
    output int            rd_ftype,
    output logic          rd_cplx
);

    real  wz1_q   [NUM_PROF];
    real  wp1_q   [NUM_PROF];
    real  wp2_q   [NUM_PROF];
    int   ftype_q [NUM_PROF];
    logic cplx_q  [NUM_PROF];

    logic rd_in_range;
    assign rd_in_range = (int'(rd_idx) < NUM_PROF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROF; i++) begin
                wz1_q[i]   <= DEF_WZ1;
                wp1_q[i]   <= DEF_WP1;
                wp2_q[i]   <= DEF_WP2;
                ftype_q[i] <= DEF_FTYPE;
                cplx_q[i]  <= DEF_CPLX;
            end
        end else if (wr_en && int'(wr_idx) < NUM_PROF) begin
            wz1_q[wr_idx]   <= wr_wz1;
            wp1_q[wr_idx]   <= wr_wp1;
            wp2_q[wr_idx]   <= wr_wp2;
            ftype_q[wr_idx] <= wr_ftype;
            cplx_q[wr_idx]  <= wr_cplx;
        end
    end

    // An index beyond the table reads back an illegal type so it is rejected.
    assign rd_wz1   = rd_in_range ? wz1_q[rd_idx]   : 0.0;
    assign rd_wp1   = rd_in_range ? wp1_q[rd_idx]   : 0.0;
    assign rd_wp2   = rd_in_range ? wp2_q[rd_idx]   : 0.0;
    assign rd_ftype = rd_in_range ? ftype_q[rd_idx] : -1;
    assign rd_cplx  = rd_in_range ? cplx_q[rd_idx]  : 1'b0;

endmodule

// File: rtl/pwl_filter_cfg_sequencer.sv
// Owns the config pins of one pwl filter: stores profiles and switches between
// them glitch-free (hold, load, optional reset pulse, release, settle, ack).
module pwl_filter_cfg_sequencer
    import pwl_filter_cfg_pkg::*;
#(
    parameter int NUM_PROF   = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RST_CYC    = 1,
    parameter int SETTLE_CYC = 16,
    localparam int PW = $clog2(NUM_PROF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_idx,
    input  real           wr_wz1,
    input  real           wr_wp1,
    input  real           wr_wp2,
    input  int            wr_ftype,
    input  logic          wr_cplx,
    input  logic          req,
    input  logic [PW-1:0] req_idx,
    input  logic          do_reset,
    output logic          ack,
    output logic          busy,
    output logic          cfg_err,
    output logic [PW-1:0] cur_idx,
    output real           wz1,
    output real           wp1,
    output real           wp2,
    output int            filter_type,
    output logic          en_complex,
    output logic          flt_hold,
    output logic          flt_reset,
    output logic [2:0]    dbg_state
);

    localparam int CNT_MAX = (HOLD_CYC > RST_CYC)
                           ? ((HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC)
                           : ((RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, reject, rd_ok;
    logic [PW-1:0] lat_idx_q;
    logic          lat_rst_q;
    profile_t      lat_prof_q, rd_prof;

    real  rd_wz1, rd_wp1, rd_wp2;
    int   rd_ftype;
    logic rd_cplx;

    pwl_filter_profile_tbl #(.NUM_PROF(NUM_PROF)) u_tbl (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_wz1   (wr_wz1),
        .wr_wp1   (wr_wp1),
        .wr_wp2   (wr_wp2),
        .wr_ftype (wr_ftype),
        .wr_cplx  (wr_cplx),
        .rd_idx   (req_idx),
        .rd_wz1   (rd_wz1),
        .rd_wp1   (rd_wp1),
        .rd_wp2   (rd_wp2),
        .rd_ftype (rd_ftype),
        .rd_cplx  (rd_cplx)
    );

    always_comb begin
        rd_prof.wz1   = rd_wz1;
        rd_prof.wp1   = rd_wp1;
        rd_prof.wp2   = rd_wp2;
        rd_prof.ftype = rd_ftype;
        rd_prof.cplx  = rd_cplx;
        rd_ok         = profile_valid(rd_prof);
    end

    // req/ack: req is a level held until ack; ack is a one-cycle pulse from
    // DONE (accepted) or REJECT (invalid profile), and req is only sampled in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        reject    = 1'b0;
        ack       = 1'b0;
        busy      = 1'b0;
        flt_hold  = 1'b0;
        flt_reset = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !ack) begin
                    if (rd_ok) begin
                        accept  = 1'b1;
                        cnt_d   = CW'(HOLD_CYC - 1);
                        state_d = ST_HOLD;
                    end else begin
                        reject  = 1'b1;
                        state_d = ST_REJECT;
                    end
                end
            end
            ST_HOLD: begin
                busy     = 1'b1;
                flt_hold = 1'b1;
                if (cnt_q == '0) state_d = ST_LOAD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_LOAD: begin
                busy     = 1'b1;
                flt_hold = 1'b1;
                if (lat_rst_q) begin
                    cnt_d   = CW'(RST_CYC - 1);
                    state_d = ST_RST;
                end else if (SETTLE_CYC == 0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CW'(SETTLE_CYC - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_RST: begin
                busy      = 1'b1;
                flt_reset = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (SETTLE_CYC == 0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CW'(SETTLE_CYC - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
                busy    = 1'b1;
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            ST_REJECT: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            lat_idx_q        <= '0;
            lat_rst_q        <= 1'b0;
            lat_prof_q.wz1   <= DEF_WZ1;
            lat_prof_q.wp1   <= DEF_WP1;
            lat_prof_q.wp2   <= DEF_WP2;
            lat_prof_q.ftype <= DEF_FTYPE;
            lat_prof_q.cplx  <= DEF_CPLX;
            cfg_err          <= 1'b0;
            cur_idx          <= '0;
            wz1              <= DEF_WZ1;
            wp1              <= DEF_WP1;
            wp2              <= DEF_WP2;
            filter_type      <= DEF_FTYPE;
            en_complex       <= DEF_CPLX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // The profile is captured at acceptance, so later table writes
            // cannot leak into a switch already in flight.
            if (accept) begin
                lat_idx_q  <= req_idx;
                lat_rst_q  <= do_reset;
                lat_prof_q <= rd_prof;
                cfg_err    <= 1'b0;
            end
            if (reject) cfg_err <= 1'b1;
            if (state_q == ST_HOLD && state_d == ST_LOAD) begin
                cur_idx     <= lat_idx_q;
                wz1         <= lat_prof_q.wz1;
                wp1         <= lat_prof_q.wp1;
                wp2         <= lat_prof_q.wp2;
                filter_type <= lat_prof_q.ftype;
                en_complex  <= lat_prof_q.cplx;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_pwl_filter_cfg_sequencer.sv
// Directed bench for the pwl filter config sequencer: defaults, switch timing,
// reset-pulse path, rejected profiles, deferred table writes and mid-sequence reset.
module tb_pwl_filter_cfg_sequencer;
    import pwl_filter_cfg_pkg::*;

    localparam int NUM_PROF   = 4;
    localparam int PW         = 2;
    localparam int HOLD_CYC   = 2;
    localparam int RST_CYC    = 1;
    localparam int SETTLE_CYC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    real           wr_wz1, wr_wp1, wr_wp2;
    int            wr_ftype;
    logic          wr_cplx;
    logic          req;
    logic [PW-1:0] req_idx;
    logic          do_reset;
    logic          ack, busy, cfg_err;
    logic [PW-1:0] cur_idx;
    real           wz1, wp1, wp2;
    int            filter_type;
    logic          en_complex, flt_hold, flt_reset;
    logic [2:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    int   ack_cyc, busy_cnt, hold_cnt, chg_cyc, rst_first, rst_cnt, overlap, ack_seen;
    logic hold_at_chg;

    pwl_filter_cfg_sequencer #(
        .NUM_PROF(NUM_PROF), .HOLD_CYC(HOLD_CYC), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_wz1(wr_wz1), .wr_wp1(wr_wp1), .wr_wp2(wr_wp2),
        .wr_ftype(wr_ftype), .wr_cplx(wr_cplx),
        .req(req), .req_idx(req_idx), .do_reset(do_reset),
        .ack(ack), .busy(busy), .cfg_err(cfg_err), .cur_idx(cur_idx),
        .wz1(wz1), .wp1(wp1), .wp2(wp2), .filter_type(filter_type), .en_complex(en_complex),
        .flt_hold(flt_hold), .flt_reset(flt_reset), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %g expected %g", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_prof(input int idx, input real a, input real b, input real c,
                              input int ft, input logic cx);
        wr_en = 1'b1; wr_idx = PW'(idx);
        wr_wz1 = a; wr_wp1 = b; wr_wp2 = c; wr_ftype = ft; wr_cplx = cx;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input real a, input real b, input real c,
                               input int ft, input logic cx, input int idx);
        chk_r({tag, "_wz1"}, wz1, a);
        chk_r({tag, "_wp1"}, wp1, b);
        chk_r({tag, "_wp2"}, wp2, c);
        chk({tag, "_ftype"}, filter_type, ft);
        chk({tag, "_cplx"}, en_complex, cx);
        chk({tag, "_cur_idx"}, cur_idx, idx);
    endtask

    // Cycle n=1 is the cycle right after the accepting clock edge.
    task automatic run_switch(input int idx, input logic dr);
        real w0;
        int  ft0;
        w0 = wz1; ft0 = filter_type;
        ack_cyc = 0; busy_cnt = 0; hold_cnt = 0; chg_cyc = 0; hold_at_chg = 1'b0;
        rst_first = 0; rst_cnt = 0; overlap = 0;
        req = 1'b1; req_idx = PW'(idx); do_reset = dr;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (busy) busy_cnt++;
            if (flt_hold) hold_cnt++;
            if (flt_reset) begin
                rst_cnt++;
                if (rst_first == 0) rst_first = n;
            end
            if (flt_hold && flt_reset) overlap++;
            if (chg_cyc == 0 && (wz1 != w0 || filter_type != ft0)) begin
                chg_cyc = n; hold_at_chg = flt_hold;
            end
            if (ack) begin
                ack_cyc = n;
                break;
            end
        end
        req = 1'b0;
        tick();
        chk("post_ack_low", ack, 0);
        chk("post_busy_low", busy, 0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_wz1 = 0.0; wr_wp1 = 0.0; wr_wp2 = 0.0;
        wr_ftype = 0; wr_cplx = 1'b0; req = 1'b0; req_idx = '0; do_reset = 1'b0;

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_hold", flt_hold, 0);
        chk("rst_freset", flt_reset, 0);
        reset = 1'b0;
        tick(); tick();
        chk_outputs("defaults", 1.0, 1.0, 2.0, 0, 1'b0, 0);
        chk("def_busy", busy, 0);
        chk("def_ack", ack, 0);
        chk("def_err", cfg_err, 0);
        chk("def_state", dbg_state, 0);

        // Plain switch to profile 1.
        write_prof(1, 1.0e9, 2.0e9, 8.0e9, 2, 1'b0);
        chk_r("write_no_effect", wz1, 1.0);
        run_switch(1, 1'b0);
        chk("sw_ack_cyc", ack_cyc, 20);
        chk("sw_busy_cnt", busy_cnt, 20);
        chk("sw_hold_cnt", hold_cnt, 3);
        chk("sw_chg_cyc", chg_cyc, 3);
        chk("sw_hold_at_chg", hold_at_chg, 1);
        chk("sw_rst_cnt", rst_cnt, 0);
        chk_outputs("sw", 1.0e9, 2.0e9, 8.0e9, 2, 1'b0, 1);
        tick();
        chk("no_double_accept", busy, 0);

        // Same profile again with a filter reset pulse.
        run_switch(1, 1'b1);
        chk("rs_ack_cyc", ack_cyc, 21);
        chk("rs_first", rst_first, 4);
        chk("rs_cnt", rst_cnt, 1);
        chk("rs_overlap", overlap, 0);
        chk("rs_hold_cnt", hold_cnt, 3);
        chk_outputs("rs", 1.0e9, 2.0e9, 8.0e9, 2, 1'b0, 1);

        // Complex poles on a first-order type are rejected.
        write_prof(2, 1.0, 1.0, 1.0, 0, 1'b1);
        run_switch(2, 1'b0);
        chk("inv_ack_cyc", ack_cyc, 1);
        chk("inv_busy_cnt", busy_cnt, 0);
        chk("inv_err", cfg_err, 1);
        chk_outputs("inv", 1.0e9, 2.0e9, 8.0e9, 2, 1'b0, 1);

        // Zero wz1 on a type that uses the zero, then an out-of-range type.
        write_prof(3, 0.0, 1.0e9, 1.0e9, 2, 1'b0);
        run_switch(3, 1'b0);
        chk("inv_wz1_ack", ack_cyc, 1);
        chk("inv_wz1_err", cfg_err, 1);
        write_prof(3, 1.0, 1.0, 1.0, 5, 1'b0);
        run_switch(3, 1'b0);
        chk("inv_type_ack", ack_cyc, 1);
        chk("inv_type_idx", cur_idx, 1);

        // Valid request clears the error.
        run_switch(0, 1'b0);
        chk("clr_ack_cyc", ack_cyc, 20);
        chk("clr_err", cfg_err, 0);
        chk_outputs("clr", 1.0, 1.0, 2.0, 0, 1'b0, 0);

        // Rewriting the active entry is deferred until it is requested again.
        write_prof(0, 3.0e9, 4.0e9, 5.0e9, 3, 1'b0);
        tick();
        chk_outputs("defer", 1.0, 1.0, 2.0, 0, 1'b0, 0);
        run_switch(0, 1'b0);
        chk("reapply_ack", ack_cyc, 20);
        chk_outputs("reapply", 3.0e9, 4.0e9, 5.0e9, 3, 1'b0, 0);

        // Asynchronous reset while settling.
        req = 1'b1; req_idx = 2'd1; do_reset = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        chk("mid_busy", busy, 1);
        chk("mid_state", dbg_state, 4);
        #2 reset = 1'b1;
        #1;
        chk_outputs("async", 1.0, 1.0, 2.0, 0, 1'b0, 0);
        chk("async_busy", busy, 0);
        chk("async_hold", flt_hold, 0);
        req = 1'b0;
        ack_seen = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (ack) ack_seen++;
        end
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (ack) ack_seen++;
        end
        chk("async_no_ack", ack_seen, 0);
        chk("async_idle", dbg_state, 0);

        // Table entries were reset as well.
        run_switch(1, 1'b0);
        chk("tblrst_ack", ack_cyc, 20);
        chk_outputs("tblrst", 1.0, 1.0, 2.0, 0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
